// File: rtl/md_unit_if.sv
// Bus between the E-stage issue logic and the multiply/divide unit.
// The master issues operations; the slave (md_unit) returns status and HI/LO.
interface md_unit_if;
  logic        START_E;
  logic [2:0]  MD_OP_E;
  logic [31:0] SRC_A_E;
  logic [31:0] SRC_B_E;
  logic        CANCEL;
  logic        BUSY;
  logic        MD_HAZARD;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (
    output START_E, MD_OP_E, SRC_A_E, SRC_B_E, CANCEL,
    input  BUSY, MD_HAZARD, HI, LO
  );

  modport slave (
    input  START_E, MD_OP_E, SRC_A_E, SRC_B_E, CANCEL,
    output BUSY, MD_HAZARD, HI, LO
  );
endinterface

// File: rtl/md_unit.sv
// Multiply/divide unit with architectural HI/LO and a fixed-latency busy window.
// Results are computed at the start edge and committed to HI/LO when the countdown expires.
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic     clk,
  input  logic     rst_n,
  md_unit_if.slave md
);
  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [31:0]      temp_hi_q, temp_hi_d;
  logic [31:0]      temp_lo_q, temp_lo_d;
  logic             commit_q, commit_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  logic             busy_q, busy_d;

  logic [31:0] a, b;
  logic [63:0] prod_s, prod_u;
  logic        a_neg, b_neg, div_by_zero;
  logic [31:0] a_mag, b_mag, b_safe_s, b_safe_u;
  logic [31:0] uq_s, ur_s, quo_s, rem_s, quo_u, rem_u;
  logic        accept;

  assign a = md.SRC_A_E;
  assign b = md.SRC_B_E;

  assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign prod_u = {32'b0, a} * {32'b0, b};

  // Signed divide done on magnitudes so 0x80000000 / -1 wraps to 0x80000000 naturally.
  assign a_neg       = a[31];
  assign b_neg       = b[31];
  assign a_mag       = a_neg ? (32'd0 - a) : a;
  assign b_mag       = b_neg ? (32'd0 - b) : b;
  assign div_by_zero = (b == 32'd0);
  assign b_safe_s    = div_by_zero ? 32'd1 : b_mag;
  assign b_safe_u    = div_by_zero ? 32'd1 : b;
  assign uq_s        = a_mag / b_safe_s;
  assign ur_s        = a_mag % b_safe_s;
  assign quo_s       = (a_neg ^ b_neg) ? (32'd0 - uq_s) : uq_s;
  assign rem_s       = a_neg ? (32'd0 - ur_s) : ur_s;
  assign quo_u       = a / b_safe_u;
  assign rem_u       = a % b_safe_u;

  assign accept = md.START_E & ~md.CANCEL & (state_q == IDLE);

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    temp_hi_d = temp_hi_q;
    temp_lo_d = temp_lo_q;
    commit_d  = commit_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    if (state_q == IDLE) begin
      if (accept) begin
        case (md.MD_OP_E)
          OP_MULT: begin
            {temp_hi_d, temp_lo_d} = prod_s;
            commit_d = 1'b1;
            count_d  = MULT_LOAD;
            state_d  = RUN;
          end
          OP_MULTU: begin
            {temp_hi_d, temp_lo_d} = prod_u;
            commit_d = 1'b1;
            count_d  = MULT_LOAD;
            state_d  = RUN;
          end
          OP_DIV: begin
            temp_hi_d = rem_s;
            temp_lo_d = quo_s;
            commit_d  = ~div_by_zero;
            count_d   = DIV_LOAD;
            state_d   = RUN;
          end
          OP_DIVU: begin
            temp_hi_d = rem_u;
            temp_lo_d = quo_u;
            commit_d  = ~div_by_zero;
            count_d   = DIV_LOAD;
            state_d   = RUN;
          end
          OP_MTHI: hi_d = a;
          OP_MTLO: lo_d = a;
          default: ;
        endcase
      end
    end else begin
      // CANCEL and START_E are deliberately ignored here: the owning instruction has retired.
      count_d = count_q - CNT_ONE;
      if (count_q == CNT_ONE) begin
        state_d = IDLE;
        if (commit_q) begin
          hi_d = temp_hi_q;
          lo_d = temp_lo_q;
        end
      end
    end
    busy_d = (count_d != '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      count_q   <= '0;
      temp_hi_q <= '0;
      temp_lo_q <= '0;
      commit_q  <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      temp_hi_q <= temp_hi_d;
      temp_lo_q <= temp_lo_d;
      commit_q  <= commit_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
    end
  end

  assign md.BUSY      = busy_q;
  assign md.HI        = hi_q;
  assign md.LO        = lo_q;
  assign md.MD_HAZARD = (md.START_E & ~md.CANCEL & ~md.MD_OP_E[2]) | busy_q;
endmodule

// File: tb/tb_md_unit.sv
// Randomized bench for md_unit against a plain-arithmetic HI/LO model.
// Inputs change 1ns after the rising edge; outputs are checked before the next edge.
module tb_md_unit;
  localparam int MULT_CYCLES = 5;
  localparam int DIV_CYCLES  = 10;

  logic clk;
  logic rst_n;
  md_unit_if bus ();

  md_unit #(.MULT_CYCLES(MULT_CYCLES), .DIV_CYCLES(DIV_CYCLES)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .md   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;
  logic [31:0] exp_hi, exp_lo;

  always @(posedge clk) begin
    if (rst_n && bus.START_E && bus.BUSY)
      $error("start issued while unit busy");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Architectural effect of one accepted operation.
  task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] p, q64, r64;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      3'd0: begin p = sa * sb; exp_hi = p[63:32]; exp_lo = p[31:0]; end
      3'd1: begin p = {32'b0, a} * {32'b0, b}; exp_hi = p[63:32]; exp_lo = p[31:0]; end
      3'd2: if (b != 0) begin
        q = sa / sb; r = sa % sb; q64 = q; r64 = r;
        exp_lo = q64[31:0]; exp_hi = r64[31:0];
      end
      3'd3: if (b != 0) begin exp_lo = a / b; exp_hi = a % b; end
      3'd4: exp_hi = a;
      3'd5: exp_lo = a;
      default: ;
    endcase
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic cancel);
    logic [31:0] old_hi, old_lo;
    logic is_md;
    int n;
    old_hi = exp_hi;
    old_lo = exp_lo;
    is_md  = (op < 3'd4);
    n      = (op < 3'd2) ? MULT_CYCLES : DIV_CYCLES;
    bus.START_E = 1'b1;
    bus.MD_OP_E = op;
    bus.SRC_A_E = a;
    bus.SRC_B_E = b;
    bus.CANCEL  = cancel;
    #1;
    check("hazard_start", bus.MD_HAZARD, is_md && !cancel);
    if (!cancel) model(op, a, b);
    tick();
    bus.START_E = 1'b0;
    bus.MD_OP_E = 3'($urandom_range(0, 7));
    bus.SRC_A_E = $urandom;
    bus.SRC_B_E = $urandom;
    if (is_md && !cancel) begin
      for (int i = 1; i <= n; i++) begin
        bus.CANCEL = ($urandom_range(0, 3) == 0);
        #1;
        check("busy_run", bus.BUSY, 1'b1);
        check("hazard_run", bus.MD_HAZARD, 1'b1);
        check("hilo_hold", {bus.HI, bus.LO}, {old_hi, old_lo});
        tick();
      end
    end
    bus.CANCEL = 1'b0;
    #1;
    check("busy_idle", bus.BUSY, 1'b0);
    check("hazard_idle", bus.MD_HAZARD, 1'b0);
    check("hi", bus.HI, exp_hi);
    check("lo", bus.LO, exp_lo);
    $display("[TB] op=%0d a=%h b=%h cancel=%0d -> hi=%h lo=%h", op, a, b, cancel, bus.HI, bus.LO);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    bus.START_E = 1'b0;
    bus.MD_OP_E = 3'd0;
    bus.SRC_A_E = 32'd0;
    bus.SRC_B_E = 32'd0;
    bus.CANCEL  = 1'b0;
    rst_n = 1'b0;
    exp_hi = 32'd0;
    exp_lo = 32'd0;
    tick();
    tick();
    check("rst_busy", bus.BUSY, 1'b0);
    check("rst_hazard", bus.MD_HAZARD, 1'b0);
    check("rst_hilo", {bus.HI, bus.LO}, 64'd0);
    rst_n = 1'b1;
    tick();

    run_op(3'd0, 32'hFFFF_FFFE, 32'd3, 1'b0);
    check("plan_mult", {bus.HI, bus.LO}, {32'hFFFF_FFFF, 32'hFFFF_FFFA});
    run_op(3'd1, 32'hFFFF_FFFE, 32'd3, 1'b0);
    check("plan_multu", {bus.HI, bus.LO}, {32'h0000_0002, 32'hFFFF_FFFA});
    run_op(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
    check("plan_div", {bus.HI, bus.LO}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    run_op(3'd4, 32'h11, 32'd0, 1'b0);
    run_op(3'd5, 32'h22, 32'd0, 1'b0);
    run_op(3'd3, 32'd7, 32'd0, 1'b0);
    check("plan_divu_zero", {bus.HI, bus.LO}, {32'h11, 32'h22});
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    check("plan_div_ovf", {bus.HI, bus.LO}, {32'h0, 32'h8000_0000});
    run_op(3'd0, 32'd9, 32'd9, 1'b1);
    check("plan_cancel", {bus.HI, bus.LO}, {32'h0, 32'h8000_0000});
    run_op(3'd5, 32'h1234, 32'd0, 1'b0);
    check("plan_mtlo", bus.LO, 32'h1234);
    run_op(3'd6, 32'hDEAD, 32'hBEEF, 1'b0);
    run_op(3'd7, 32'hDEAD, 32'hBEEF, 1'b0);

    // Reset landing in busy cycle 4 of a divide must discard the result.
    bus.START_E = 1'b1;
    bus.MD_OP_E = 3'd2;
    bus.SRC_A_E = 32'd100;
    bus.SRC_B_E = 32'd7;
    tick();
    bus.START_E = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      check("rst_mid_busy", bus.BUSY, 1'b1);
      tick();
    end
    rst_n = 1'b0;
    tick();
    exp_hi = 32'd0;
    exp_lo = 32'd0;
    check("rst_mid_busy_clr", bus.BUSY, 1'b0);
    check("rst_mid_hilo", {bus.HI, bus.LO}, 64'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("rst_no_late_write", {bus.HI, bus.LO, 31'd0, bus.BUSY}, 96'd0);
    end
    $display("[TB] reset mid-divide -> hi=%h lo=%h", bus.HI, bus.LO);

    for (int t = 0; t < 300; t++) begin
      run_op(3'($urandom_range(0, 7)), pick_operand(), pick_operand(),
             ($urandom_range(0, 9) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/md_unit.md
# md_unit

Multiply/divide unit for the pipelined MIPS core, sitting in the E stage directly downstream of the D-stage controller/hazard logic. It accepts MULT, MULTU, DIV, DIVU, MTHI and MTLO operations, holds the architectural HI/LO registers, and models multi-cycle latency with a BUSY countdown. It also exports the stall request that the hazard unit uses to hold D-stage HI/LO-dependent instructions.

## Interface
- MULT_CYCLES, default 5: busy cycles after a multiply start.
- DIV_CYCLES, default 10: busy cycles after a divide start.
- clk  in  1  core clock; all state changes on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- START_E  in  1  single-cycle start strobe for the E-stage instruction.
- MD_OP_E  in  3  operation select:
  - 000 MULT
  - 001 MULTU
  - 010 DIV
  - 011 DIVU
  - 100 MTHI
  - 101 MTLO
  - 11x reserved, treated as no-op.
- SRC_A_E  in  32  forwarded rs operand.
- SRC_B_E  in  32  forwarded rt operand.
- CANCEL  in  1  exception/interrupt flush of the E-stage instruction this cycle.
- BUSY  out  1  registered; high while an operation is in flight.
- MD_HAZARD  out  1  combinational: (START_E & ~CANCEL & MD_OP_E is mult/div) | BUSY.
- HI  out  32  architectural HI register.
- LO  out  32  architectural LO register.

## Operation
- Reset (rst_n=0 at an edge) sets HI=0, LO=0, BUSY=0 and count=0. Any in-flight result is discarded.
- States: IDLE (count=0) and RUN (count>0); BUSY = (count != 0).
- Accepted start: START_E=1 & CANCEL=0 & state IDLE.
  - For MULT/MULTU/DIV/DIVU, the edge latches the result into internal temp_hi/temp_lo.
  - The same edge loads count with MULT_CYCLES or DIV_CYCLES and moves to RUN.
- MTHI/MTLO write SRC_A_E into HI/LO at the start edge, with no busy period.
- RUN: count decrements by 1 per edge. On the edge where count==1, HI<=temp_hi, LO<=temp_lo and count->0 (IDLE).
- MULT/MULTU arithmetic: full 64-bit product (signed or unsigned). HI = product[63:32], LO = product[31:0].
- DIV arithmetic: signed, truncating toward zero. LO = quotient; HI = remainder, with the sign of the dividend.
- DIVU arithmetic: unsigned.
- DIV special case: 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- Divide by zero: the full DIV_CYCLES busy period still runs; HI/LO are left unchanged at completion.
- START_E while RUN: ignored. The hazard unit guarantees this never happens; the bench asserts on it.
- CANCEL with START_E: no state change of any kind.
- CANCEL during RUN: no effect. The operation's instruction has already retired past E and must complete.
- Reserved op: no state change.

## Timing
- Start edge at cycle 0. BUSY is high in cycles 1..N (N = MULT_CYCLES or DIV_CYCLES).
- New HI/LO values are visible in cycle N+1, the first cycle with BUSY=0.
- A new start is accepted in cycle N+1.
- MTHI/MTLO: new value visible in cycle 1; BUSY stays 0.
- MD_HAZARD rises combinationally in cycle 0 and falls in cycle N+1.
- HI/LO are stable throughout RUN; readers see the old values until completion.
- Reset asserted in any cycle of RUN: BUSY=0 and HI=LO=0 in the following cycle.

## Test plan
- MULT with A=0xFFFFFFFE, B=3: BUSY high for 5 cycles. In cycle 6, HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- MULTU with the same operands: HI=0x00000002, LO=0xFFFFFFFA after 5 busy cycles.
- DIV with A=0xFFFFFFF9 (-7), B=2: BUSY for 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU with A=7, B=0 and prior HI=0x11, LO=0x22: 10 busy cycles, then HI=0x11, LO=0x22 unchanged.
- Cancel/MTxx sequence:
  - START_E MULT with CANCEL=1: BUSY stays 0 and HI/LO are unchanged.
  - Next cycle, MTLO with A=0x1234: LO=0x1234 one cycle later and BUSY=0.
- Reset mid-op: DIV started, rst_n=0 in busy cycle 4. Next cycle BUSY=0, HI=LO=0. No late write occurs in cycle 11.
